pdm_modulator: RTL

PDM_MODULATOR -- requirements
Module: pdm_modulator

---
 rtl/pdm_pkg.sv | 31 +++
 rtl/pdm_sd_core.sv | 87 ++++++++
 rtl/pdm_modulator.sv | 119 +++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdm_pkg
// Brief    : Shared constants, types and helpers for the PDM modulator.
// Revision : 1.0 - initial release
// ============================================================================
package pdm_pkg;

  // Default system clock and PDM bit-clock frequencies (Hz)
  localparam int unsigned PDM_DEF_INPUT_FREQ  = 100_000_000;
  localparam int unsigned PDM_DEF_OUTPUT_FREQ = 480_000;

  // Default PCM sample width and oversampling ratio
  localparam int unsigned PDM_DEF_PCM_WIDTH = 16;
  localparam int unsigned PDM_DEF_OSR       = 10;

  // Extra accumulator bits above the sample width; leaves headroom for
  // the +/-2^(PCM_WIDTH+2) saturation limits plus the sign bit.
  localparam int unsigned PDM_ACC_GUARD = 4;

  // Signed PCM sample at the default width
  typedef logic signed [PDM_DEF_PCM_WIDTH-1:0] pcm_sample_t;

  // Half-period of the PDM bit clock in system clocks (truncating divide)
  function automatic int unsigned pdm_half(input int unsigned in_hz,
                                           input int unsigned out_hz);
    return in_hz / (2 * out_hz);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_sd_core.sv
`default_nettype none
// ============================================================================
// Module   : pdm_sd_core
// Brief    : Sigma-delta accumulator/quantizer, advanced once per tick.
//            Optional macro PDM_MOD_SECOND_ORDER_EN selects the second-order
//            loop; the default build is first order.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_sd_core
  import pdm_pkg::*;
#(
  parameter int PCM_WIDTH = PDM_DEF_PCM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick_i,
  input  logic signed [PCM_WIDTH-1:0] sample_i,
  output logic                        bit_o
);

  // Stored accumulator width and the wider width used for raw sums so that
  // no intermediate result can wrap before saturation.
  localparam int AW = PCM_WIDTH + int'(PDM_ACC_GUARD);
  localparam int EW = AW + 2;

  // Feedback magnitude FS = 2^(PCM_WIDTH-1) and saturation limit 2^(PCM_WIDTH+2)
  localparam logic signed [EW-1:0] FS_P  = {{(EW-PCM_WIDTH){1'b0}}, 1'b1, {(PCM_WIDTH-1){1'b0}}};
  localparam logic signed [EW-1:0] FS_N  = -FS_P;
  localparam logic signed [EW-1:0] LIM_P = {{(EW-PCM_WIDTH-3){1'b0}}, 1'b1, {(PCM_WIDTH+2){1'b0}}};
  localparam logic signed [EW-1:0] LIM_N = -LIM_P;

  // Clamp a wide sum into the stored accumulator range
  function automatic logic signed [AW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > LIM_P) begin
      return LIM_P[AW-1:0];
    end else if (v < LIM_N) begin
      return LIM_N[AW-1:0];
    end else begin
      return v[AW-1:0];
    end
  endfunction

  logic                 pdm_q, pdm_d;
  logic signed [AW-1:0] acc1_q, acc1_d;
  logic signed [EW-1:0] fb_e, sample_e, acc1_e;
`ifdef PDM_MOD_SECOND_ORDER_EN
  logic signed [AW-1:0] acc2_q, acc2_d;
  logic signed [EW-1:0] acc2_e, acc1d_e;
`endif

  // Next accumulator state and quantized bit for the coming tick
  always_comb begin
    fb_e     = pdm_q ? FS_P : FS_N;
    sample_e = {{(EW-PCM_WIDTH){sample_i[PCM_WIDTH-1]}}, sample_i};
    acc1_e   = {{(EW-AW){acc1_q[AW-1]}}, acc1_q};
    acc1_d   = sat(acc1_e + sample_e - fb_e);
`ifdef PDM_MOD_SECOND_ORDER_EN
    acc1d_e  = {{(EW-AW){acc1_d[AW-1]}}, acc1_d};
    acc2_e   = {{(EW-AW){acc2_q[AW-1]}}, acc2_q};
    acc2_d   = sat(acc2_e + acc1d_e - fb_e);
    pdm_d    = ~acc2_d[AW-1];
`else
    pdm_d    = ~acc1_d[AW-1];
`endif
  end

  // Loop state only advances on a tick; reset returns to a zero state
  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_q  <= 1'b0;
      acc1_q <= '0;
`ifdef PDM_MOD_SECOND_ORDER_EN
      acc2_q <= '0;
`endif
    end else if (tick_i) begin
      pdm_q  <= pdm_d;
      acc1_q <= acc1_d;
`ifdef PDM_MOD_SECOND_ORDER_EN
      acc2_q <= acc2_d;
`endif
    end
  end

  assign bit_o = pdm_q;

endmodule
`default_nettype wire

// File: rtl/pdm_modulator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_modulator
// Brief    : PCM-to-PDM modulator with bit-clock divider, one-entry sample
//            buffer and underrun flag. Optional macro PDM_MOD_SECOND_ORDER_EN
//            selects a second-order sigma-delta loop (default: first order).
// Revision : 1.0 - initial release
// ============================================================================
module pdm_modulator
  import pdm_pkg::*;
#(
  parameter int unsigned INPUT_FREQ  = PDM_DEF_INPUT_FREQ,
  parameter int unsigned OUTPUT_FREQ = PDM_DEF_OUTPUT_FREQ,
  parameter int          PCM_WIDTH   = PDM_DEF_PCM_WIDTH,
  parameter int unsigned OSR         = PDM_DEF_OSR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [PCM_WIDTH-1:0] pcm_data,
  input  logic                        pcm_valid,
  output logic                        pcm_ready,
  output logic                        AUD_CLK,
  output logic                        aud_clk_rising,
  output logic                        AUD_PDM,
  output logic                        underrun
);

  localparam int unsigned HALF  = pdm_half(INPUT_FREQ, OUTPUT_FREQ);
  localparam int          DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int          OSR_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

  // Bit-clock divider state
  logic [DIV_W-1:0] div_q, div_d;
  logic             aud_clk_q, rise_q;
  logic             div_wrap;

  // Sample buffering state
  logic [OSR_W-1:0]            osr_q;
  logic signed [PCM_WIDTH-1:0] cur_q, nxt_q;
  logic                        nxt_full_q, armed_q, underrun_q;
  logic                        boundary, accept;

  // Divider next state; the half-period ends when the count reaches HALF-1
  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_wrap ? '0 : div_q + 1'b1;
  end

  // Toggle the bit clock each half-period and strobe its rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      aud_clk_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      div_q  <= div_d;
      rise_q <= div_wrap & ~aud_clk_q;
      if (div_wrap) begin
        aud_clk_q <= ~aud_clk_q;
      end
    end
  end

  // A sample boundary is the tick that completes OSR bits of one sample
  always_comb begin
    boundary = rise_q && (osr_q == OSR_LAST);
    accept   = pcm_valid && !nxt_full_q;
  end

  // Tick counting, buffer promotion at boundaries and producer handshake.
  // Acceptance never coincides with a promotion because ready is low while
  // the buffer is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      osr_q      <= '0;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      armed_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (rise_q) begin
        osr_q <= boundary ? '0 : osr_q + 1'b1;
      end
      if (boundary) begin
        if (nxt_full_q) begin
          cur_q      <= nxt_q;
          nxt_full_q <= 1'b0;
        end else if (armed_q) begin
          underrun_q <= 1'b1;
        end
      end
      if (accept) begin
        nxt_q      <= pcm_data;
        nxt_full_q <= 1'b1;
        armed_q    <= 1'b1;
      end
    end
  end

  pdm_sd_core #(
    .PCM_WIDTH (PCM_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (rise_q),
    .sample_i (cur_q),
    .bit_o    (AUD_PDM)
  );

  assign pcm_ready      = ~nxt_full_q;
  assign AUD_CLK        = aud_clk_q;
  assign aud_clk_rising = rise_q;
  assign underrun       = underrun_q;

endmodule
`default_nettype wire
